// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit processor fetch path.
// Provides address/offset widths, the fetch FSM state type and the
// branch-offset sign-extension helper.
package cpu_pkg;

  localparam int WIDTH = 12;
  localparam int OFF_W = 6;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Sign-extend a PC-relative branch offset to address width.
  function automatic logic [WIDTH-1:0] sext(input logic [OFF_W-1:0] off);
    sext = {{(WIDTH-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, presents it to decode through a
// valid/ready handshake, feeds the external next-PC adder and captures its
// sum on every retired fetch. Includes start/halt control and a saturating
// retire counter.
// Optional build macro: PC_WRAP_TRAP_EN -- a PC wrap on a non-jump fetch
// halts the unit and raises fault_o. Without it, wraps are silent and
// fault_o is tied low.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             instr_ready_i,
  input  logic             branch_taken_i,
  input  logic [OFF_W-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             halt_i,
  input  logic [WIDTH-1:0] adder_sum_i,
  output logic [WIDTH-1:0] adder_d0_o,
  output logic [WIDTH-1:0] adder_d1_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             instr_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             fault_o
);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  logic             fire_s;
  logic [WIDTH-1:0] offset_ext_s;
  logic [WIDTH-1:0] pc_d;
  logic             trap_s;

  assign fire_s       = valid_q & instr_ready_i;
  assign offset_ext_s = sext(branch_offset_i);

  // The adder always sees the current PC and either +1 or the branch offset.
  assign adder_d0_o = pc_q;
  assign adder_d1_o = branch_taken_i ? offset_ext_s : {{(WIDTH-1){1'b0}}, 1'b1};

  // Jump overrides the adder result; branch/increment both come from the adder.
  assign pc_d = jump_i ? jump_target_i : adder_sum_i;

`ifdef PC_WRAP_TRAP_EN
  logic wrap_s;

  // Detect modulo wrap of the sequential or PC-relative next address.
  always_comb begin
    wrap_s = 1'b0;
    if (!branch_taken_i) begin
      wrap_s = (pc_q == {WIDTH{1'b1}});
    end else if (branch_offset_i[OFF_W-1]) begin
      wrap_s = (adder_sum_i > pc_q);
    end else begin
      wrap_s = (adder_sum_i < pc_q);
    end
  end

  assign trap_s  = wrap_s & ~jump_i;
  assign fault_o = fault_q;
`else
  assign trap_s  = 1'b0;
  assign fault_o = 1'b0;
`endif

  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign retired_o     = cnt_q;

  // Fetch FSM with PC, handshake, halt, fault and retire-count registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            valid_q <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        RUN: begin
          if (fire_s) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (halt_i) begin
              // HALT retires but the PC stays on the halting instruction.
              state_q  <= HALTED;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
            end else if (trap_s) begin
              state_q  <= HALTED;
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        HALTED: begin
          if (start_i) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          pc_q     <= RESET_PC;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. The bench plays the role of the
// external next-PC adder. Expected values are hand-computed constants.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             start_i;
  logic             instr_ready_i;
  logic             branch_taken_i;
  logic [OFF_W-1:0] branch_offset_i;
  logic             jump_i;
  logic [WIDTH-1:0] jump_target_i;
  logic             halt_i;
  logic [WIDTH-1:0] adder_sum_i;
  logic [WIDTH-1:0] adder_d0_o;
  logic [WIDTH-1:0] adder_d1_o;
  logic [WIDTH-1:0] pc_o;
  logic             instr_valid_o;
  logic             halted_o;
  logic [CNT_W-1:0] retired_o;
  logic             fault_o;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_i         (start_i),
    .instr_ready_i   (instr_ready_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .halt_i          (halt_i),
    .adder_sum_i     (adder_sum_i),
    .adder_d0_o      (adder_d0_o),
    .adder_d1_o      (adder_d1_o),
    .pc_o            (pc_o),
    .instr_valid_o   (instr_valid_o),
    .halted_o        (halted_o),
    .retired_o       (retired_o),
    .fault_o         (fault_o)
  );

  // External adder model.
  assign adder_sum_i = adder_d0_o + adder_d1_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i         = 1'b0;
    instr_ready_i   = 1'b0;
    branch_taken_i  = 1'b0;
    branch_offset_i = 6'h00;
    jump_i          = 1'b0;
    jump_target_i   = 12'h000;
    halt_i          = 1'b0;
  endtask

  task automatic do_jump(input logic [WIDTH-1:0] tgt);
    idle_inputs();
    instr_ready_i = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = tgt;
    step();
    idle_inputs();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},      32'(pc_o),          32'h000);
    check({tag, "_valid"},   32'(instr_valid_o), 32'h0);
    check({tag, "_halted"},  32'(halted_o),      32'h0);
    check({tag, "_retired"}, 32'(retired_o),     32'h0);
    check({tag, "_fault"},   32'(fault_o),       32'h0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    check_reset_vals("rst");

    // Start: valid the cycle after start_i.
    reset_n = 1'b1;
    start_i = 1'b1;
    check("pre_start_valid", 32'(instr_valid_o), 32'h0);
    step();
    start_i = 1'b0;
    check("start_valid", 32'(instr_valid_o), 32'h1);

    // 1: four sequential fetches.
    instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_pc%0d", i), 32'(pc_o), i);
      check($sformatf("seq_valid%0d", i), 32'(instr_valid_o), 32'h1);
      #1;
      check($sformatf("seq_d1_%0d", i), 32'(adder_d1_o), 32'h001);
      step();
    end
    instr_ready_i = 1'b0;
    check("seq_retired", 32'(retired_o), 32'd4);
    check("seq_pc4", 32'(pc_o), 32'h004);

    // 2: negative then positive branch from 0x010.
    do_jump(12'h010);
    check("jmp10_pc", 32'(pc_o), 32'h010);
    instr_ready_i   = 1'b1;
    branch_taken_i  = 1'b1;
    branch_offset_i = 6'h3D;
    #1;
    check("br_neg_d1", 32'(adder_d1_o), 32'hFFD);
    step();
    idle_inputs();
    check("br_neg_pc", 32'(pc_o), 32'h00D);
    do_jump(12'h010);
    instr_ready_i   = 1'b1;
    branch_taken_i  = 1'b1;
    branch_offset_i = 6'h05;
    #1;
    check("br_pos_d1", 32'(adder_d1_o), 32'h005);
    step();
    idle_inputs();
    check("br_pos_pc", 32'(pc_o), 32'h015);

    // 3: jump wins over branch.
    instr_ready_i   = 1'b1;
    jump_i          = 1'b1;
    jump_target_i   = 12'h2A0;
    branch_taken_i  = 1'b1;
    branch_offset_i = 6'h05;
    step();
    idle_inputs();
    check("jmp_prio_pc", 32'(pc_o), 32'h2A0);
    check("jmp_prio_retired", 32'(retired_o), 32'd9);

    // 4: stall with jump pulsing.
    for (int i = 0; i < 3; i++) begin
      instr_ready_i = 1'b0;
      jump_i        = (i != 1);
      jump_target_i = 12'h123;
      step();
    end
    idle_inputs();
    check("stall_pc", 32'(pc_o), 32'h2A0);
    check("stall_retired", 32'(retired_o), 32'd9);
    check("stall_valid", 32'(instr_valid_o), 32'h1);

    // 5: halt at 0x0FF, then restart.
    do_jump(12'h0FF);
    instr_ready_i = 1'b1;
    halt_i        = 1'b1;
    step();
    idle_inputs();
    check("halt_halted", 32'(halted_o), 32'h1);
    check("halt_valid", 32'(instr_valid_o), 32'h0);
    check("halt_pc", 32'(pc_o), 32'h0FF);
    check("halt_retired", 32'(retired_o), 32'd11);
    instr_ready_i = 1'b1;
    step();
    check("halt_hold_pc", 32'(pc_o), 32'h0FF);
    check("halt_hold_retired", 32'(retired_o), 32'd11);
    instr_ready_i = 1'b0;
    start_i       = 1'b1;
    step();
    idle_inputs();
    check("restart_pc", 32'(pc_o), 32'h000);
    check("restart_valid", 32'(instr_valid_o), 32'h1);
    check("restart_halted", 32'(halted_o), 32'h0);
    check("restart_retired", 32'(retired_o), 32'd11);

    // start_i in RUN is ignored.
    start_i = 1'b1;
    step();
    idle_inputs();
    check("run_start_pc", 32'(pc_o), 32'h000);
    check("run_start_valid", 32'(instr_valid_o), 32'h1);

    // 6: increment from 0xFFF.
    do_jump(12'hFFF);
    check("wrap_pre_pc", 32'(pc_o), 32'hFFF);
    instr_ready_i = 1'b1;
    step();
    idle_inputs();
    check("wrap_retired", 32'(retired_o), 32'd13);
`ifdef PC_WRAP_TRAP_EN
    check("wrap_pc", 32'(pc_o), 32'hFFF);
    check("wrap_halted", 32'(halted_o), 32'h1);
    check("wrap_fault", 32'(fault_o), 32'h1);
    start_i = 1'b1;
    step();
    idle_inputs();
    check("wrap_clr_fault", 32'(fault_o), 32'h0);
    check("wrap_clr_pc", 32'(pc_o), 32'h000);
`else
    check("wrap_pc", 32'(pc_o), 32'h000);
    check("wrap_halted", 32'(halted_o), 32'h0);
    check("wrap_valid", 32'(instr_valid_o), 32'h1);
    check("wrap_fault", 32'(fault_o), 32'h0);
`endif

    // Reset in the middle of running.
    do_jump(12'h055);
    check("mid_pre_pc", 32'(pc_o), 32'h055);
    instr_ready_i = 1'b1;
    reset_n       = 1'b0;
    step();
    idle_inputs();
    check_reset_vals("mid_rst");
    reset_n = 1'b1;
    step();
    check("post_rst_valid", 32'(instr_valid_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
